// File: rtl/fetch_queue.sv
// Decoupling FIFO between the fetch stage and decode: buffers instruction packets
// so fetch keeps running while decode stalls, and a redirect flush empties it in one cycle.
module fetch_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [WIDTH-1:0]         push_inst,
   input  logic [WIDTH-1:0]         push_pc,
   input  logic [WIDTH-1:0]         push_pc4,
   input  logic                     push_bp_en,
   input  logic                     push_bp_dec,
   output logic                     pop_valid,
   input  logic                     pop_ready,
   output logic [WIDTH-1:0]         pop_inst,
   output logic [WIDTH-1:0]         pop_pc,
   output logic [WIDTH-1:0]         pop_pc4,
   output logic                     pop_bp_en,
   output logic                     pop_bp_dec,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 3 * WIDTH + 2;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [WIDTH-1:0] NOP_INST = WIDTH'(32'h0000_0013);

   // Packed entry layout, MSB first: inst, pc, pc4, bp_en, bp_dec
   localparam int INST_LSB = 2 * WIDTH + 2;
   localparam int PC_LSB   = WIDTH + 2;
   localparam int PC4_LSB  = 2;

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               push_acc;
   logic               pop_acc;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   assign push_ready = (count_q != FULL_CNT);
   assign pop_valid  = (count_q != '0);
   assign count      = count_q;

   // A push in the flush cycle must not land in the array either.
   assign push_acc   = push_valid & push_ready & ~flush;
   assign pop_acc    = pop_valid & pop_ready;

   assign push_entry = {push_inst, push_pc, push_pc4, push_bp_en, push_bp_dec};
   assign head_entry = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Array contents are don't-care until written, so no reset here.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   always_comb begin
      pop_inst   = NOP_INST;
      pop_pc     = '0;
      pop_pc4    = '0;
      pop_bp_en  = 1'b0;
      pop_bp_dec = 1'b0;
      if (pop_valid) begin
         pop_inst   = head_entry[INST_LSB +: WIDTH];
         pop_pc     = head_entry[PC_LSB +: WIDTH];
         pop_pc4    = head_entry[PC4_LSB +: WIDTH];
         pop_bp_en  = head_entry[1];
         pop_bp_dec = head_entry[0];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based packet model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        bp_en;
      logic        bp_dec;
   } pkt_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        push_valid = 1'b0;
   logic        push_ready;
   logic [31:0] push_inst = '0;
   logic [31:0] push_pc = '0;
   logic [31:0] push_pc4 = '0;
   logic        push_bp_en = 1'b0;
   logic        push_bp_dec = 1'b0;
   logic        pop_valid;
   logic        pop_ready = 1'b0;
   logic [31:0] pop_inst;
   logic [31:0] pop_pc;
   logic [31:0] pop_pc4;
   logic        pop_bp_en;
   logic        pop_bp_dec;
   logic [2:0]  count;

   int   n_checks = 0;
   int   n_pass = 0;
   bit   cmp_en = 1'b0;
   pkt_t model_q[$];

   fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_inst   (push_inst),
      .push_pc     (push_pc),
      .push_pc4    (push_pc4),
      .push_bp_en  (push_bp_en),
      .push_bp_dec (push_bp_dec),
      .pop_valid   (pop_valid),
      .pop_ready   (pop_ready),
      .pop_inst    (pop_inst),
      .pop_pc      (pop_pc),
      .pop_pc4     (pop_pc4),
      .pop_bp_en   (pop_bp_en),
      .pop_bp_dec  (pop_bp_dec),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic pv, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic en, input logic dec, input logic pr, input logic fl);
      push_valid  = pv;
      push_inst   = inst;
      push_pc     = pc;
      push_pc4    = pc + 32'd4;
      push_bp_en  = en;
      push_bp_dec = dec;
      pop_ready   = pr;
      flush       = fl;
      @(posedge clk);
      #1;
   endtask

   // Reference model: a packet queue updated by the accept rules at each edge
   always @(posedge clk or negedge rst) begin : model
      bit   do_push;
      bit   do_pop;
      pkt_t p;
      if (!rst) begin
         model_q.delete();
      end else if (flush) begin
         model_q.delete();
      end else begin
         do_push = push_valid && (model_q.size() < DEPTH);
         do_pop  = pop_ready && (model_q.size() > 0);
         if (do_pop) begin
            model_q.delete(0);
         end
         if (do_push) begin
            p.inst   = push_inst;
            p.pc     = push_pc;
            p.pc4    = push_pc4;
            p.bp_en  = push_bp_en;
            p.bp_dec = push_bp_dec;
            model_q.push_back(p);
         end
      end
   end

   always @(negedge clk) begin : compare
      int n;
      if (cmp_en) begin
         n = model_q.size();
         check_output("count", 64'(count), 64'(n));
         check_output("push_ready", 64'(push_ready), 64'(n != DEPTH));
         check_output("pop_valid", 64'(pop_valid), 64'(n != 0));
         if (n != 0) begin
            check_output("pop_inst", 64'(pop_inst), 64'(model_q[0].inst));
            check_output("pop_pc", 64'(pop_pc), 64'(model_q[0].pc));
            check_output("pop_pc4", 64'(pop_pc4), 64'(model_q[0].pc4));
            check_output("pop_bp", 64'({pop_bp_en, pop_bp_dec}), 64'({model_q[0].bp_en, model_q[0].bp_dec}));
         end else begin
            check_output("pop_inst_nop", 64'(pop_inst), 64'h13);
            check_output("pop_idle", 64'({pop_pc, pop_pc4, pop_bp_en, pop_bp_dec}), 64'h0);
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      cmp_en = 1'b1;
      @(posedge clk);
      #3 rst = 1'b1;
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("rst_count", 64'(count), 64'd0);
      check_output("rst_push_ready", 64'(push_ready), 64'd1);
      check_output("rst_pop_inst", 64'(pop_inst), 64'h13);

      // Reset in the middle of traffic with three entries held
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, 32'h0000_0093 + 32'(i), 32'h40 + 32'(4 * i), 0, 0, 0, 0);
      end
      check_output("t1_count3", 64'(count), 64'd3);
      push_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_output("t1_count", 64'(count), 64'd0);
      check_output("t1_pop_valid", 64'(pop_valid), 64'd0);
      check_output("t1_pop_inst", 64'(pop_inst), 64'h13);
      check_output("t1_push_ready", 64'(push_ready), 64'd1);
      #1 rst = 1'b1;
      apply_stimulus(0, 0, 0, 0, 0, 1, 0);
      check_output("t1_after_count", 64'(count), 64'd0);

      // Fill, drop the fifth push, then drain in order
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1, 32'h0010_0093 + 32'(i), 32'(4 * i), 0, 0, 0, 0);
      end
      check_output("t2_count", 64'(count), 64'd4);
      check_output("t2_push_ready", 64'(push_ready), 64'd0);
      apply_stimulus(1, 32'h0010_0099, 32'd16, 0, 0, 0, 0);
      check_output("t2_drop_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check_output("t2_pop_pc", 64'(pop_pc), 64'(4 * i));
         apply_stimulus(0, 0, 0, 0, 0, 1, 0);
      end
      check_output("t2_empty", 64'(pop_valid), 64'd0);

      // Streaming through the wrap point, one packet in flight
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1, 32'h0020_0013 + 32'(i), 32'h100 + 32'(4 * i), 1'(i % 2), 1'((i / 2) % 2), 1, 0);
         check_output("t3_count", 64'(count), 64'd1);
         check_output("t3_pop_pc", 64'(pop_pc), 64'(32'h100 + 32'(4 * i)));
         check_output("t3_pop_bp", 64'({pop_bp_en, pop_bp_dec}), 64'({1'(i % 2), 1'((i / 2) % 2)}));
      end
      apply_stimulus(0, 0, 0, 0, 0, 1, 0);
      check_output("t3_drain", 64'(count), 64'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1, 32'h0030_0013 + 32'(i), 32'h200 + 32'(4 * i), 0, 1, 0, 0);
      end
      apply_stimulus(1, 32'h0030_0099, 32'h210, 0, 0, 1, 0);
      check_output("t4_count", 64'(count), 64'd3);
      check_output("t4_push_ready", 64'(push_ready), 64'd1);
      check_output("t4_head", 64'(pop_pc), 64'h204);
      for (int i = 1; i < 4; i++) begin
         check_output("t4_pop_pc", 64'(pop_pc), 64'(32'h200 + 32'(4 * i)));
         apply_stimulus(0, 0, 0, 0, 0, 1, 0);
      end
      check_output("t4_empty", 64'(count), 64'd0);

      // Flush overrides concurrent push and pop
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, 32'h0040_0013 + 32'(i), 32'h300 + 32'(4 * i), 1, 0, 0, 0);
      end
      apply_stimulus(1, 32'h0040_0099, 32'h30C, 0, 0, 1, 1);
      check_output("t5_count", 64'(count), 64'd0);
      check_output("t5_pop_valid", 64'(pop_valid), 64'd0);
      apply_stimulus(1, 32'h0040_00AA, 32'h400, 1, 1, 0, 0);
      check_output("t5_fresh_pc", 64'(pop_pc), 64'h400);
      check_output("t5_fresh_pc4", 64'(pop_pc4), 64'h404);
      apply_stimulus(0, 0, 0, 0, 0, 1, 0);

      // Push into empty with pop_ready high: no same-cycle bypass
      apply_stimulus(1, 32'h0050_0093, 32'h500, 0, 0, 1, 0);
      check_output("t6_count", 64'(count), 64'd1);
      check_output("t6_pop_valid", 64'(pop_valid), 64'd1);
      check_output("t6_pop_inst", 64'(pop_inst), 64'h0050_0093);
      apply_stimulus(0, 0, 0, 0, 0, 1, 0);
      check_output("t6_drain", 64'(count), 64'd0);

      repeat (2) @(posedge clk);
      cmp_en = 1'b0;
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
